// File: rtl/ysyx_040066_mem_arbiter.sv
// Merges the core's instruction-fetch and data ports onto one req/ack bus, data first, with a bus watchdog.
// Optional one-entry fetch line buffer: define YSYX_040066_IFETCH_BUF_EN.
module ysyx_040066_mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic [63:0] pc_rd,
    output logic [31:0] instr_rd,
    output logic        instr_valid,
    output logic        instr_error,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [63:0] addr,
    input  logic [2:0]  wr_len,
    input  logic [7:0]  wr_mask,
    input  logic [63:0] data_Wr,
    input  logic        fence_i,
    output logic [63:0] data_Rd,
    output logic        data_valid,
    output logic        data_error,
    output logic        bus_req,
    output logic        bus_wen,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wmask,
    output logic [2:0]  bus_len,
    input  logic        bus_ack,
    input  logic [63:0] bus_rdata,
    input  logic        bus_err
);

    localparam int unsigned CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0]  FETCH_LEN = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DREQ = 3'd1,
        S_FREQ = 3'd2,
        S_DRSP = 3'd3,
        S_FRSP = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   wd_cnt;
    logic               wd_expire;
    logic               mem_req;
    logic               misalign;
    logic               in_req;
    logic               buf_hit;
    logic [63:0]        buf_line;

    logic               req_wen;
    logic [63:0]        req_addr;
    logic [63:0]        req_wdata;
    logic [7:0]         req_wmask;
    logic [2:0]         req_len;
    logic [63:0]        lat_pc;
    logic [63:0]        rsp_data;
    logic               rsp_err;

    assign mem_req   = MemRd | MemWr;
    assign misalign  = (pc_rd[1:0] != 2'b00);
    assign in_req    = (state == S_DREQ) || (state == S_FREQ);
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == CNT_W'(TIMEOUT - 1));

`ifdef YSYX_040066_IFETCH_BUF_EN
    logic        buf_valid;
    logic [60:0] buf_tag;
    logic [63:0] buf_data;

    // Fill on a clean fetch ack; fence_i or a write to the buffered line invalidates it.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= RESET_PC[63:3];
            buf_data  <= '0;
        end else begin
            if (state == S_FREQ && bus_ack && !bus_err) begin
                buf_valid <= 1'b1;
                buf_tag   <= req_addr[63:3];
                buf_data  <= bus_rdata;
            end
            if (fence_i || (state == S_DREQ && req_wen && req_addr[63:3] == buf_tag)) begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign buf_hit  = buf_valid && (pc_rd[63:3] == buf_tag);
    assign buf_line = buf_data;
`else
    logic unused_cfg;
    assign unused_cfg = ^{fence_i, RESET_PC};
    assign buf_hit    = 1'b0;
    assign buf_line   = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (mem_req) begin
                    state_nxt = S_DREQ;
                end else if (instr_read) begin
                    state_nxt = (misalign || buf_hit) ? S_FRSP : S_FREQ;
                end
            end
            S_DREQ:  if (bus_ack || wd_expire) state_nxt = S_DRSP;
            S_FREQ:  if (bus_ack || wd_expire) state_nxt = S_FRSP;
            S_DRSP:  state_nxt = S_IDLE;
            S_FRSP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus_req     = in_req;
        bus_wen     = req_wen;
        bus_addr    = req_addr;
        bus_wdata   = req_wdata;
        bus_wmask   = req_wmask;
        bus_len     = req_len;
        data_Rd     = rsp_data;
        data_valid  = (state == S_DRSP);
        data_error  = (state == S_DRSP) && rsp_err;
        instr_rd    = lat_pc[2] ? rsp_data[63:32] : rsp_data[31:0];
        // A redirected or dropped fetch is silently discarded.
        instr_valid = (state == S_FRSP) && instr_read && (pc_rd == lat_pc);
        instr_error = instr_valid && rsp_err;
    end

    // Request fields are captured once at IDLE exit and held for the whole bus access.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_wen   <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wmask <= '0;
            req_len   <= '0;
            lat_pc    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        req_wen   <= MemWr;
                        req_addr  <= addr;
                        req_wdata <= data_Wr;
                        req_wmask <= wr_mask;
                        req_len   <= wr_len;
                    end else if (instr_read) begin
                        lat_pc <= pc_rd;
                        if (misalign) begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end else if (buf_hit) begin
                            rsp_data <= buf_line;
                            rsp_err  <= 1'b0;
                        end else begin
                            req_wen   <= 1'b0;
                            req_addr  <= {pc_rd[63:3], 3'b000};
                            req_wdata <= '0;
                            req_wmask <= '0;
                            req_len   <= FETCH_LEN;
                        end
                    end
                end
                S_DREQ, S_FREQ: begin
                    if (bus_ack) begin
                        rsp_data <= bus_rdata;
                        rsp_err  <= bus_err;
                    end else if (wd_expire) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Watchdog counts waiting cycles and restarts from zero on every state exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (in_req && state_nxt == state) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// Directed bench for ysyx_040066_mem_arbiter: table-driven single transactions plus multi-cycle sequences.
module tb_ysyx_040066_mem_arbiter;

    localparam int          K_READ  = 0;
    localparam int          K_WRITE = 1;
    localparam int          K_FETCH = 2;
    localparam int          NEVER   = 255;
    localparam int          NVEC    = 10;
    localparam logic [63:0] JUNK    = 64'hDEAD_DEAD_DEAD_DEAD;

    logic        clk;
    logic        rst;
    logic        instr_read;
    logic [63:0] pc_rd;
    logic [31:0] instr_rd;
    logic        instr_valid;
    logic        instr_error;
    logic        MemRd;
    logic        MemWr;
    logic [63:0] addr;
    logic [2:0]  wr_len;
    logic [7:0]  wr_mask;
    logic [63:0] data_Wr;
    logic        fence_i;
    logic [63:0] data_Rd;
    logic        data_valid;
    logic        data_error;
    logic        bus_req;
    logic        bus_wen;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;
    logic [2:0]  bus_len;
    logic        bus_ack;
    logic [63:0] bus_rdata;
    logic        bus_err;

    ysyx_040066_mem_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .instr_read(instr_read), .pc_rd(pc_rd), .instr_rd(instr_rd),
        .instr_valid(instr_valid), .instr_error(instr_error),
        .MemRd(MemRd), .MemWr(MemWr), .addr(addr), .wr_len(wr_len), .wr_mask(wr_mask),
        .data_Wr(data_Wr), .fence_i(fence_i),
        .data_Rd(data_Rd), .data_valid(data_valid), .data_error(data_error),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wmask(bus_wmask), .bus_len(bus_len),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [63:0] a;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [2:0]  len;
        int          ack_wait;
        logic [63:0] rdata;
        logic        rerr;
        int          exp_cyc;
        logic [63:0] exp_baddr;
        logic [63:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t vecs[NVEC];
    vec_t v;
    int   checks;
    int   errors;
    int   req_cyc;
    int   gap;
    bit   got;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus_ack   = 1'b0;
        bus_rdata = JUNK;
        bus_err   = 1'b1;
    endtask

    task automatic ack_bus(input logic [63:0] d, input logic e);
        bus_ack   = 1'b1;
        bus_rdata = d;
        bus_err   = e;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; instr_read = 1'b0; pc_rd = '0; MemRd = 1'b0; MemWr = 1'b0;
        addr = '0; wr_len = '0; wr_mask = '0; data_Wr = '0; fence_i = 1'b0;
        idle_bus();

        //            kind     addr                   wdata                  mask   len   ack    rdata                  err  cyc baddr                  out                    err
        vecs[0] = '{K_FETCH, 64'h0000_0000_8000_0004, 64'h0, 8'h00, 3'd0, 0,     64'h1111_2222_3333_4444, 1'b0, 1, 64'h0000_0000_8000_0000, 64'h1111_2222,          1'b0};
        vecs[1] = '{K_FETCH, 64'h0000_0000_8000_0008, 64'h0, 8'h00, 3'd0, 2,     64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 3, 64'h0000_0000_8000_0008, 64'hCCCC_DDDD,          1'b0};
        vecs[2] = '{K_READ,  64'h0000_0000_8000_0100, 64'h0, 8'h00, 3'd3, 0,     64'h0123_4567_89AB_CDEF, 1'b0, 1, 64'h0000_0000_8000_0100, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[3] = '{K_WRITE, 64'h0000_0000_8000_0208, 64'hDEAD_BEEF_0000_1111, 8'h0F, 3'd2, 1, 64'h0, 1'b0, 2, 64'h0000_0000_8000_0208, 64'h0,                  1'b0};
        vecs[4] = '{K_READ,  64'h0000_0000_0000_0013, 64'h0, 8'h00, 3'd0, 3,     64'h55,                  1'b1, 4, 64'h0000_0000_0000_0013, 64'h55,                 1'b1};
        vecs[5] = '{K_FETCH, 64'h0000_0000_8000_0014, 64'h0, 8'h00, 3'd0, 0,     64'h0000_0099_0000_0077, 1'b1, 1, 64'h0000_0000_8000_0010, 64'h99,                 1'b1};
        vecs[6] = '{K_FETCH, 64'h0000_0000_8000_0002, 64'h0, 8'h00, 3'd0, NEVER, 64'h0,                  1'b0, 0, 64'h0,                  64'h0,                  1'b1};
        vecs[7] = '{K_WRITE, 64'h0000_0000_0000_0300, 64'h1234, 8'hFF, 3'd3, NEVER, 64'h0,                1'b0, 8, 64'h0000_0000_0000_0300, 64'h0,                  1'b1};
        vecs[8] = '{K_FETCH, 64'h0000_0000_8000_0024, 64'h0, 8'h00, 3'd0, NEVER, 64'h0,                  1'b0, 8, 64'h0000_0000_8000_0020, 64'h0,                  1'b1};
        vecs[9] = '{K_READ,  64'h0000_0000_8000_0400, 64'h0, 8'h00, 3'd3, 7,     64'hCAFE_F00D_1234_5678, 1'b0, 8, 64'h0000_0000_8000_0400, 64'hCAFE_F00D_1234_5678, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk1("rst_data_valid", data_valid, 1'b0);
        chk1("rst_errors", instr_error | data_error, 1'b0);
        chk64("rst_data_rd", data_Rd, 64'h0);
        chk64("rst_instr_rd", 64'(instr_rd), 64'h0);
        rst = 1'b0;

        // Reset while a data request is on the bus, then a stale ack
        @(negedge clk); MemRd = 1'b1; addr = 64'h40;
        @(negedge clk); chk1("rstmid_req_up", bus_req, 1'b1);
        rst = 1'b1; MemRd = 1'b0;
        @(negedge clk); chk1("rstmid_req_dropped", bus_req, 1'b0);
        rst = 1'b0; ack_bus(64'h1234, 1'b0);
        @(negedge clk); idle_bus();
        chk1("stale_ack_no_valid", data_valid, 1'b0);
        chk1("stale_ack_no_req", bus_req, 1'b0);
        @(negedge clk); chk1("stale_ack_still_idle", data_valid | instr_valid | bus_req, 1'b0);

        // Table of single transactions
        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            @(negedge clk);
            if (v.kind == K_FETCH) begin
                instr_read = 1'b1; pc_rd = v.a;
            end else begin
                MemRd = (v.kind == K_READ); MemWr = (v.kind == K_WRITE);
                addr = v.a; data_Wr = v.wdata; wr_mask = v.wmask; wr_len = v.len;
            end
            req_cyc = 0; gap = 0; got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                idle_bus();
                if (bus_req) begin
                    if (req_cyc == 0) begin
                        chk64($sformatf("v%0d_bus_addr", i), bus_addr, v.exp_baddr);
                        chk1($sformatf("v%0d_bus_wen", i), bus_wen, v.kind == K_WRITE);
                        if (v.kind != K_FETCH) begin
                            chk64($sformatf("v%0d_bus_wdata", i), bus_wdata, v.wdata);
                            chk64($sformatf("v%0d_bus_wmask", i), 64'(bus_wmask), 64'(v.wmask));
                            chk64($sformatf("v%0d_bus_len", i), 64'(bus_len), 64'(v.len));
                        end
                    end
                    if (req_cyc == v.ack_wait) ack_bus(v.rdata, v.rerr);
                    req_cyc++;
                end else if (data_valid || instr_valid) begin
                    got = 1'b1;
                    chk64($sformatf("v%0d_req_cycles", i), 64'(req_cyc), 64'(v.exp_cyc));
                    chk64($sformatf("v%0d_latency_gap", i), 64'(gap), 64'h0);
                    if (v.kind == K_FETCH) begin
                        chk1($sformatf("v%0d_kind", i), instr_valid & ~data_valid, 1'b1);
                        chk64($sformatf("v%0d_instr_rd", i), 64'(instr_rd), v.exp_out);
                        chk1($sformatf("v%0d_instr_error", i), instr_error, v.exp_err);
                    end else begin
                        chk1($sformatf("v%0d_kind", i), data_valid & ~instr_valid, 1'b1);
                        chk64($sformatf("v%0d_data_rd", i), data_Rd, v.exp_out);
                        chk1($sformatf("v%0d_data_error", i), data_error, v.exp_err);
                    end
                    instr_read = 1'b0; MemRd = 1'b0; MemWr = 1'b0;
                end else begin
                    gap++;
                end
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL v%0d_response actual=none required=valid within 40 cycles", i);
                instr_read = 1'b0; MemRd = 1'b0; MemWr = 1'b0;
            end
            @(negedge clk);
            chk1($sformatf("v%0d_post_idle", i), bus_req | data_valid | instr_valid, 1'b0);
        end

        // Simultaneous data and fetch request: data goes first
        @(negedge clk); MemRd = 1'b1; addr = 64'h8000_0100; instr_read = 1'b1; pc_rd = 64'h8000_0000;
        @(negedge clk); chk1("both_req", bus_req, 1'b1);
        chk64("both_first_addr", bus_addr, 64'h8000_0100);
        ack_bus(64'h0A0A_0B0B_0C0C_0D0D, 1'b0);
        @(negedge clk); idle_bus();
        chk1("both_data_valid", data_valid, 1'b1);
        chk64("both_data_rd", data_Rd, 64'h0A0A_0B0B_0C0C_0D0D);
        chk1("both_no_instr_yet", instr_valid, 1'b0);
        MemRd = 1'b0;
        @(negedge clk); chk1("both_gap_idle", bus_req, 1'b0);
        @(negedge clk); chk1("both_fetch_req", bus_req, 1'b1);
        chk64("both_fetch_addr", bus_addr, 64'h8000_0000);
        ack_bus(64'h1357_9BDF_2468_ACE0, 1'b0);
        @(negedge clk); idle_bus();
        chk1("both_instr_valid", instr_valid, 1'b1);
        chk64("both_instr_rd", 64'(instr_rd), 64'h2468_ACE0);
        instr_read = 1'b0;

        // Data request arriving during a fetch waits for the fetch
        @(negedge clk); instr_read = 1'b1; pc_rd = 64'h8000_0040;
        @(negedge clk); chk64("dinf_fetch_addr", bus_addr, 64'h8000_0040);
        MemRd = 1'b1; addr = 64'h8000_0500;
        @(negedge clk); chk1("dinf_fetch_held", bus_req, 1'b1);
        chk64("dinf_fetch_addr_held", bus_addr, 64'h8000_0040);
        ack_bus(64'h7777_6666_5555_4444, 1'b0);
        @(negedge clk); idle_bus();
        chk1("dinf_instr_valid", instr_valid, 1'b1);
        chk64("dinf_instr_rd", 64'(instr_rd), 64'h5555_4444);
        chk1("dinf_no_data_yet", data_valid, 1'b0);
        instr_read = 1'b0;
        @(negedge clk); chk1("dinf_gap_idle", bus_req, 1'b0);
        @(negedge clk); chk1("dinf_data_req", bus_req, 1'b1);
        chk64("dinf_data_addr", bus_addr, 64'h8000_0500);
        ack_bus(64'h0F0F_0000_F0F0_1111, 1'b0);
        @(negedge clk); idle_bus();
        chk1("dinf_data_valid", data_valid, 1'b1);
        chk64("dinf_data_rd", data_Rd, 64'h0F0F_0000_F0F0_1111);
        MemRd = 1'b0;

        // Redirect while a fetch is in flight
        @(negedge clk); instr_read = 1'b1; pc_rd = 64'h8000_0000;
        @(negedge clk); chk64("redir_first_addr", bus_addr, 64'h8000_0000);
        pc_rd = 64'h8000_0040;
        @(negedge clk); chk64("redir_addr_stable", bus_addr, 64'h8000_0000);
        ack_bus(64'h1111_1111_1111_1111, 1'b0);
        @(negedge clk); idle_bus();
        chk1("redir_discard", instr_valid, 1'b0);
        @(negedge clk); chk1("redir_idle", bus_req | instr_valid, 1'b0);
        @(negedge clk); chk1("redir_new_req", bus_req, 1'b1);
        chk64("redir_new_addr", bus_addr, 64'h8000_0040);
        ack_bus(64'h2222_3333_4444_5555, 1'b0);
        @(negedge clk); idle_bus();
        chk1("redir_valid", instr_valid, 1'b1);
        chk64("redir_instr_rd", 64'(instr_rd), 64'h4444_5555);
        instr_read = 1'b0;

`ifdef YSYX_040066_IFETCH_BUF_EN
        // Fetch buffer hit, then fence_i forces a refetch
        @(negedge clk); fence_i = 1'b1;
        @(negedge clk); fence_i = 1'b0; instr_read = 1'b1; pc_rd = 64'h8000_0000;
        @(negedge clk); chk1("buf_miss_req", bus_req, 1'b1);
        ack_bus(64'hABCD_0001_1234_0000, 1'b0);
        @(negedge clk); idle_bus();
        chk1("buf_fill_valid", instr_valid, 1'b1);
        pc_rd = 64'h8000_0004;
        @(negedge clk); chk1("buf_hit_no_req", bus_req, 1'b0);
        @(negedge clk); chk1("buf_hit_valid", instr_valid, 1'b1);
        chk1("buf_hit_no_req2", bus_req, 1'b0);
        chk64("buf_hit_instr_rd", 64'(instr_rd), 64'hABCD_0001);
        instr_read = 1'b0; fence_i = 1'b1;
        @(negedge clk); fence_i = 1'b0; instr_read = 1'b1; pc_rd = 64'h8000_0000;
        @(negedge clk); chk1("buf_fence_refetch", bus_req, 1'b1);
        ack_bus(64'hABCD_0001_1234_0000, 1'b0);
        @(negedge clk); idle_bus();
        chk1("buf_refetch_valid", instr_valid, 1'b1);
        instr_read = 1'b0;
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
